// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch / prefetch stage. Issues byte fetches to
//               program memory over a single-outstanding req/ack handshake,
//               buffers fetched {byte, address} pairs in a small FIFO and
//               presents the head to the control unit via valid/ready.
//               A pc_load redirects fetch, flushes the FIFO and discards the
//               data of any request still in flight on the old path.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W   - program address width (PC wraps modulo 2**ADDR_W)
//   DEPTH    - prefetch FIFO entries, power of two, >= 2
//   RESET_PC - first fetch address after reset
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   mem_req, mem_addr   - registered fetch request / address
//   mem_ack, mem_rdata  - memory accepts request, byte valid same cycle
//   IR_out, ir_pc       - head byte and its address (hold when empty)
//   ir_valid, ir_ready  - head handshake with the control unit
//   pc_load,
//   pc_load_addr        - fetch redirect
//   stall_cnt           - saturating starvation counter, present only when
//                         IFU_STALL_CNT_EN is defined
// ============================================================================
module ifetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        IR_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // FIFO storage (no reset needed: contents are only read behind count)
  logic [7:0]        fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              drop, drop_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        ir_nxt;
  logic [ADDR_W-1:0] ir_pc_nxt;

  logic acked;
  logic push;
  logic pop;
  logic still_pending;

  assign acked         = mem_req & mem_ack;
  // A redirect discards a same-cycle ack as well as the one marked by drop.
  assign push          = acked & ~drop & ~pc_load;
  assign pop           = ir_valid & ir_ready & ~pc_load;
  assign still_pending = mem_req & ~mem_ack;
  assign ir_valid      = (count != '0);

  // --------------------------------------------------------------------------
  // FIFO bookkeeping, fetch PC and drop flag
  // --------------------------------------------------------------------------
  always_comb begin
    count_nxt    = count;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;

    if (pc_load) begin
      count_nxt    = '0;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      fetch_pc_nxt = pc_load_addr;
      // Only a request that survives this cycle can return stale data.
      // Repeated redirects simply re-evaluate this, so one ack is dropped.
      drop_nxt     = still_pending;
    end else begin
      if (acked) begin
        drop_nxt = 1'b0;
        if (!drop) begin
          fetch_pc_nxt = mem_addr + ADDR_ONE;
        end
      end
      if (push) begin
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Request issue: hold while outstanding; otherwise issue when the FIFO,
  // after this cycle's push/pop/flush, still has a free slot for the reply.
  // --------------------------------------------------------------------------
  always_comb begin
    req_nxt  = 1'b0;
    addr_nxt = mem_addr;
    if (still_pending) begin
      req_nxt  = 1'b1;
      addr_nxt = mem_addr;
    end else if (count_nxt < DEPTH_C) begin
      req_nxt  = 1'b1;
      addr_nxt = fetch_pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered head view. When the new head is the entry being written this
  // cycle (FIFO empty after the pop), take it straight from the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    ir_nxt    = IR_out;
    ir_pc_nxt = ir_pc;
    if (count_nxt != '0) begin
      if (push && (count_nxt == CNT_ONE)) begin
        ir_nxt    = mem_rdata;
        ir_pc_nxt = mem_addr;
      end else begin
        ir_nxt    = fifo_data[rd_ptr_nxt];
        ir_pc_nxt = fifo_addr[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      IR_out   <= 8'h00;
      ir_pc    <= RESET_PC;
    end else begin
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      count    <= count_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      IR_out   <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_addr[wr_ptr] <= mem_addr;
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Counts cycles the consumer was ready but had nothing to take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (ir_ready && !ir_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch and prefetch stage that sits directly upstream of the control unit. Fetches 8-bit instruction bytes from program memory over a single-outstanding request/acknowledge handshake and buffers them in a small prefetch FIFO. Presents the head byte as `IR_out`, together with its address, to the control unit through a valid/ready pair. Redirects fetch on a PC load (branch/jump) and discards stale data.

## Interface
Parameters:
- `ADDR_W`, 8: program address width; PC wraps modulo 2^ADDR_W.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0: fetch address after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request (registered).
- `mem_addr`  out  ADDR_W  fetch address (registered).
- `mem_ack`  in  1  memory accepts request; `mem_rdata` valid this cycle.
- `mem_rdata`  in  8  fetched byte.
- `IR_out`  out  8  instruction byte at FIFO head.
- `ir_valid`  out  1  `IR_out` holds a valid byte.
- `ir_ready`  in  1  control unit consumes head byte.
- `ir_pc`  out  ADDR_W  address of the `IR_out` byte.
- `pc_load`  in  1  redirect fetch.
- `pc_load_addr`  in  ADDR_W  new fetch address.
- `stall_cnt`  out  16  starvation counter; present only with `IFU_STALL_CNT_EN`.

## Operation
- State: `fetch_pc`, `req_pending` (drives `mem_req`), `drop` flag, FIFO storing {byte, address}, `count` of 0..DEPTH.
- Request rule: once asserted, `mem_req` and `mem_addr` stay stable until `mem_ack`. At most one request is outstanding.
- Issue: `mem_req` goes to 1 at the next edge when no request is pending, or when one is acked this cycle, and the post-update count plus in-flight requests is < DEPTH.
- On `mem_ack` without `drop`: push {`mem_rdata`, `mem_addr`}; `fetch_pc` ← `mem_addr`+1, wrapping to 0 after 2^ADDR_W−1.
- Pop: `ir_valid & ir_ready` removes the head. Push and pop in the same cycle leave `count` unchanged.
- `ir_valid` = (`count` != 0). `IR_out` and `ir_pc` show head contents; when empty they hold their last value.
- `pc_load` takes priority over everything:
  - Flush the FIFO (`count` ← 0) and ignore any simultaneous pop.
  - Set `fetch_pc` ← `pc_load_addr`.
  - If a request is pending and not acked this cycle, set `drop`. The pending request completes on the old address and its ack data is discarded, then `drop` clears.
  - An ack arriving in the same cycle as `pc_load` is discarded.
- Multiple `pc_load` pulses while `drop` is set: the last address wins, and only one ack is discarded.
- FIFO overflow is impossible by construction. A push never occurs when `count` = DEPTH.

## Timing
- Reset (async assert, sync-safe release): `mem_req`=0, `mem_addr`=RESET_PC, `ir_valid`=0, `IR_out`=8'h00, `ir_pc`=RESET_PC, `stall_cnt`=0, FIFO empty, `drop`=0.
- First `mem_req` is asserted on the first rising edge after `rst_n` deasserts.
- Ack at cycle t gives `ir_valid`=1 at t+1 (one-cycle fill latency).
- Back-to-back: with `mem_ack` tied high and the consumer always ready, the unit sustains one byte per cycle, and `mem_addr` increments every cycle.
- `pc_load` at t with no pending request: `mem_req` with `mem_addr`=`pc_load_addr` at t+1, first redirected byte valid at t+2 at the earliest.
- `pc_load` at t with a pending request acked at t+k: new request at t+k+1.
- `ir_valid` is 0 from t+1 after `pc_load` until the first redirected byte arrives.

## Configuration
- `IFU_STALL_CNT_EN` defined: the `stall_cnt` port exists.
  - It increments each cycle with `ir_ready`=1 and `ir_valid`=0.
  - It saturates at 16'hFFFF and is cleared only by reset.
- `IFU_STALL_CNT_EN` undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset then stream, with `mem_ack`=1, `mem_rdata`=addr^8'hA5, and `ir_ready`=1:
  - `mem_addr` runs 0,1,2,… from cycle 1.
  - `IR_out`=8'hA5 with `ir_pc`=0 at cycle 2.
  - One byte per cycle thereafter.
- Backpressure, `ir_ready`=0: exactly DEPTH (4) bytes are fetched, then `mem_req` drops. Raising `ir_ready` drains them in order 0..3 and fetching resumes at addr 4.
- Redirect mid-flight: hold `mem_ack`=0 with a request on addr 5, pulse `pc_load` with addr 8'h40, then ack 2 cycles later.
  - The byte from addr 5 never appears on `IR_out`.
  - The next `mem_addr` is 8'h40, and the first valid `ir_pc` is 8'h40.
- Simultaneous events: `pc_load`, `mem_ack` and `ir_ready` together with FIFO holding 3 bytes. The FIFO empties, the acked byte is dropped, and the next request is on `pc_load_addr`.
- Wrap-around: `pc_load_addr`=8'hFE → fetch addresses FE, FF, 00, 01, with `ir_pc` matching.
- With `IFU_STALL_CNT_EN`: keep `mem_ack`=0 for 10 cycles after reset with `ir_ready`=1 → `stall_cnt`=10. A long stall holds it at 16'hFFFF.
